tap_writer: RTL and testbench



---
 rtl/oric_tap_pkg.sv | 41 ++++
 rtl/tap_writer_if.sv | 14 +
 rtl/tap_out_reg.sv | 57 +++++
 rtl/tap_writer.sv | 221 ++++++++++++++++++++++
 tb/tb_tap_writer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oric_tap_pkg.sv
// Shared constants and types for the Oric tape subsystem (writer and loader).
//   TAP_SYNC / TAP_MARKER  : leader sync byte and block marker
//   FT_* / AUTORUN_*       : file type and autorun header codes
//   HDR_*                  : header byte offsets counted from the marker byte
//   state_e                : tap_writer controller states
package oric_tap_pkg;

  localparam logic [7:0] TAP_SYNC    = 8'h16;
  localparam logic [7:0] TAP_MARKER  = 8'h24;
  localparam logic [7:0] FT_BASIC    = 8'h00;
  localparam logic [7:0] FT_MCODE    = 8'h80;
  localparam logic [7:0] AUTORUN_OFF = 8'h00;
  localparam logic [7:0] AUTORUN_ON  = 8'hC7;

  // Header layout, offsets relative to the marker byte.
  localparam int HDR_MARKER   = 0;
  localparam int HDR_RSVD0    = 1;
  localparam int HDR_RSVD1    = 2;
  localparam int HDR_TYPE     = 3;
  localparam int HDR_AUTORUN  = 4;
  localparam int HDR_END_HI   = 5;
  localparam int HDR_END_LO   = 6;
  localparam int HDR_START_HI = 7;
  localparam int HDR_START_LO = 8;
  localparam int HDR_RSVD2    = 9;
  localparam int HDR_LEN      = 10;

  // RD/WAIT/HOLD together form the data phase: read, present, hold until accepted.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HEADER,
    ST_NAME,
    ST_NAMEEND,
    ST_RD,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tap_writer_if.sv
// Byte stream from the TAP writer toward the tape cache / upload buffer.
//   tap_valid : byte on tap_dout is valid
//   tap_ready : sink accepts the byte this cycle
//   tap_addr  : offset of the byte within the image
//   tap_dout  : image byte
interface tap_writer_if;
  logic        tap_valid;
  logic        tap_ready;
  logic [16:0] tap_addr;
  logic [7:0]  tap_dout;

  modport master (output tap_valid, output tap_addr, output tap_dout, input tap_ready);
  modport slave  (input tap_valid, input tap_addr, input tap_dout, output tap_ready);
endinterface

// File: rtl/tap_out_reg.sv
// Output byte register and image offset counter for the TAP writer.
//   restart   : clear the offset counter (first byte of a new image)
//   load      : capture load_data as a new valid byte
//   bypass    : present load_data directly this cycle (RAM data arriving);
//               it is captured and held if the sink does not take it
//   accepted  : a transfer happens this cycle
//   count     : current image offset (bytes accepted so far)
//   tap       : valid/ready byte stream
module tap_out_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  input  logic        load,
  input  logic        bypass,
  input  logic [7:0]  load_data,
  output logic        accepted,
  output logic [16:0] count,
  tap_writer_if.master tap
);

  logic        valid_q;
  logic [7:0]  dout_q;
  logic [16:0] count_q;

  // valid depends only on state, never on tap_ready.
  assign tap.tap_valid = valid_q | bypass;
  assign tap.tap_dout  = bypass ? load_data : dout_q;
  assign tap.tap_addr  = count_q;
  assign accepted      = tap.tap_valid & tap.tap_ready;
  assign count         = count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      dout_q  <= 8'h00;
      count_q <= '0;
    end else begin
      if (load) begin
        valid_q <= 1'b1;
        dout_q  <= load_data;
      end else if (bypass) begin
        // Keep the byte only if the sink refused it.
        valid_q <= ~tap.tap_ready;
        dout_q  <= load_data;
      end else if (accepted) begin
        valid_q <= 1'b0;
      end

      if (restart)
        count_q <= '0;
      else if (accepted)
        count_q <= count_q + 17'd1;
    end
  end

endmodule

// File: rtl/tap_writer.sv
// Oric TAP image generator. On start, streams sync bytes, marker, header,
// filename, terminator and then RAM[start_addr..end_addr] over a valid/ready
// byte interface.
//   start/start_addr/end_addr/file_type/autorun/file_name : save request
//   mem_rd/mem_addr/mem_din : RAM read port, data one cycle after mem_rd
//   tap        : output byte stream (master side)
//   busy       : save in progress
//   done       : pulse the cycle after the last byte is accepted
//   error      : pulse when a start with end_addr < start_addr is rejected
//   tap_length : total image bytes, valid from done until the next start
module tap_writer
  import oric_tap_pkg::*;
#(
  parameter int NAME_LEN   = 16,
  parameter int SYNC_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           start_addr,
  input  logic [15:0]           end_addr,
  input  logic [7:0]            file_type,
  input  logic [7:0]            autorun,
  input  logic [8*NAME_LEN-1:0] file_name,
  output logic                  mem_rd,
  output logic [15:0]           mem_addr,
  input  logic [7:0]            mem_din,
  tap_writer_if.master          tap,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [16:0]           tap_length
);

  localparam int             IW        = $clog2(SYNC_COUNT + HDR_LEN) + 1;
  localparam logic [IW-1:0]  SYNC_LAST = IW'(SYNC_COUNT - 1);
  localparam logic [IW-1:0]  HDR_LAST  = IW'(HDR_LEN - 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [15:0]            cur_q, cur_d;
  logic [15:0]            start_q, end_q;
  logic [7:0]             type_q, autorun_q;
  // One spare zero byte on top so the "next character" read is always in range.
  logic [8*NAME_LEN+7:0]  name_q, name_d;
  logic                   err_q, err_d;
  logic                   latch;

  logic        load, bypass, restart, accepted;
  logic [7:0]  load_data, hdr_next;
  logic [16:0] count;

  tap_out_reg u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (restart),
    .load      (load),
    .bypass    (bypass),
    .load_data (load_data),
    .accepted  (accepted),
    .count     (count),
    .tap       (tap)
  );

  // Header byte that follows the one currently held.
  always_comb begin
    hdr_next = 8'h00;
    case (int'(idx_q) + 1)
      HDR_MARKER:   hdr_next = TAP_MARKER;
      HDR_RSVD0:    hdr_next = 8'h00;
      HDR_RSVD1:    hdr_next = 8'h00;
      HDR_TYPE:     hdr_next = type_q;
      HDR_AUTORUN:  hdr_next = autorun_q;
      HDR_END_HI:   hdr_next = end_q[15:8];
      HDR_END_LO:   hdr_next = end_q[7:0];
      HDR_START_HI: hdr_next = start_q[15:8];
      HDR_START_LO: hdr_next = start_q[7:0];
      HDR_RSVD2:    hdr_next = 8'h00;
      default:      hdr_next = 8'h00;
    endcase
  end

  // Each streaming state describes the byte currently held; an accept
  // loads the following byte in the same cycle so there are no bubbles.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    name_d    = name_q;
    err_d     = 1'b0;
    latch     = 1'b0;
    load      = 1'b0;
    bypass    = 1'b0;
    restart   = 1'b0;
    load_data = 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (end_addr < start_addr) begin
            err_d = 1'b1;
          end else begin
            latch     = 1'b1;
            restart   = 1'b1;
            load      = 1'b1;
            load_data = TAP_SYNC;
            idx_d     = '0;
            cur_d     = start_addr;
            name_d    = {8'h00, file_name};
            state_d   = ST_SYNC;
          end
        end
      end

      ST_SYNC: begin
        if (accepted) begin
          load = 1'b1;
          if (idx_q == SYNC_LAST) begin
            load_data = TAP_MARKER;
            idx_d     = '0;
            state_d   = ST_HEADER;
          end else begin
            load_data = TAP_SYNC;
            idx_d     = idx_q + 1'b1;
          end
        end
      end

      ST_HEADER: begin
        if (accepted) begin
          load = 1'b1;
          if (idx_q == HDR_LAST) begin
            // An empty name goes straight to the terminator.
            load_data = name_q[7:0];
            state_d   = (name_q[7:0] == 8'h00) ? ST_NAMEEND : ST_NAME;
          end else begin
            load_data = hdr_next;
            idx_d     = idx_q + 1'b1;
          end
        end
      end

      ST_NAME: begin
        // The name is shifted down a byte per accept; zero fill means a
        // full-length name also ends on a 0x00, which doubles as the terminator.
        if (accepted) begin
          load      = 1'b1;
          load_data = name_q[15:8];
          name_d    = name_q >> 8;
          if (name_q[15:8] == 8'h00)
            state_d = ST_NAMEEND;
        end
      end

      ST_NAMEEND: begin
        if (accepted)
          state_d = ST_RD;
      end

      ST_RD: state_d = ST_WAIT;

      ST_WAIT, ST_HOLD: begin
        if (state_q == ST_WAIT) begin
          bypass    = 1'b1;
          load_data = mem_din;
        end
        if (accepted) begin
          // Equality stop, so a range ending at 0xFFFF never relies on wrap.
          if (cur_q == end_q) begin
            state_d = ST_DONE;
          end else begin
            cur_d   = cur_q + 16'd1;
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cur_q     <= 16'h0000;
      start_q   <= 16'h0000;
      end_q     <= 16'h0000;
      type_q    <= 8'h00;
      autorun_q <= 8'h00;
      name_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      name_q  <= name_d;
      err_q   <= err_d;
      if (latch) begin
        start_q   <= start_addr;
        end_q     <= end_addr;
        type_q    <= file_type;
        autorun_q <= autorun;
      end
    end
  end

  assign mem_rd     = (state_q == ST_RD);
  assign mem_addr   = cur_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign error      = err_q;
  // The offset counter already equals the image length once the last byte is taken.
  assign tap_length = (state_q == ST_IDLE || state_q == ST_DONE) ? count : 17'd0;

endmodule

// File: tb/tb_tap_writer.sv
// Self-checking bench for tap_writer: a reference model builds each expected
// image into a scoreboard queue; a monitor pops and compares on every transfer.
module tb_tap_writer;
  import oric_tap_pkg::*;

  localparam int NAME_LEN   = 16;
  localparam int SYNC_COUNT = 3;
  localparam int NW         = 8 * NAME_LEN;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   start_addr = 16'h0000;
  logic [15:0]   end_addr = 16'h0000;
  logic [7:0]    file_type = 8'h00;
  logic [7:0]    autorun = 8'h00;
  logic [NW-1:0] file_name = '0;
  logic          mem_rd;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_din = 8'h00;
  logic          busy, done, error;
  logic [16:0]   tap_length;

  tap_writer_if tap_bus();

  tap_writer #(.NAME_LEN(NAME_LEN), .SYNC_COUNT(SYNC_COUNT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .file_type  (file_type),
    .autorun    (autorun),
    .file_name  (file_name),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .tap        (tap_bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .tap_length (tap_length)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [65536];
  exp_t       exp_q [$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         rd_cnt = 0;
  bit         rnd_ready_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Synchronous-read RAM model.
  always @(posedge clk) begin
    if (mem_rd) mem_din <= ram[mem_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    tap_bus.tap_ready = rnd_ready_en ? ($urandom_range(0, 9) < 6) : 1'b1;
  end

  // Monitor: scoreboard pops, hold stability, read-while-held, pulse counters.
  bit          held = 1'b0;
  logic [7:0]  h_dout;
  logic [16:0] h_addr;
  always @(negedge clk) begin
    if (!reset_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(tap_bus.tap_valid), 32'd1);
        check("hold_dout", 32'(tap_bus.tap_dout), 32'(h_dout));
        check("hold_addr", 32'(tap_bus.tap_addr), 32'(h_addr));
      end
      if (mem_rd) begin
        rd_cnt++;
        check("rd_while_held", 32'(tap_bus.tap_valid), 32'd0);
      end
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (tap_bus.tap_valid && tap_bus.tap_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got addr %0h data %0h expected none", tap_bus.tap_addr, tap_bus.tap_dout);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (tap_bus.tap_addr !== e.addr || tap_bus.tap_dout !== e.data) begin
            errors++;
            $display("FAIL stream_byte: got addr %0h data %0h expected addr %0h data %0h",
                     tap_bus.tap_addr, tap_bus.tap_dout, e.addr, e.data);
          end
        end
        acc_cyc = cyc;
      end
      held   = tap_bus.tap_valid && !tap_bus.tap_ready;
      h_dout = tap_bus.tap_dout;
      h_addr = tap_bus.tap_addr;
    end
  end

  function automatic logic [NW-1:0] pack_name(input string s);
    logic [NW-1:0] r = '0;
    for (int i = 0; i < s.len() && i < NAME_LEN; i++)
      r = r | (NW'(s[i]) << (8 * i));
    return r;
  endfunction

  // Reference image built directly from the layout rules; returns its length.
  function automatic int build_image(input logic [15:0] sa, input logic [15:0] ea,
                                     input logic [7:0] ft, input logic [7:0] ar, input string nm);
    logic [7:0] img [$];
    for (int i = 0; i < SYNC_COUNT; i++) img.push_back(8'h16);
    img.push_back(8'h24);
    img.push_back(8'h00);
    img.push_back(8'h00);
    img.push_back(ft);
    img.push_back(ar);
    img.push_back(ea[15:8]);
    img.push_back(ea[7:0]);
    img.push_back(sa[15:8]);
    img.push_back(sa[7:0]);
    img.push_back(8'h00);
    for (int i = 0; i < nm.len() && i < NAME_LEN; i++) img.push_back(8'(nm[i]));
    img.push_back(8'h00);
    for (int k = 0; k <= int'(ea) - int'(sa); k++) img.push_back(ram[16'(int'(sa) + k)]);
    for (int i = 0; i < img.size(); i++) exp_q.push_back('{addr: 17'(i), data: img[i]});
    return img.size();
  endfunction

  task automatic pulse_start(input logic [15:0] sa, input logic [15:0] ea,
                             input logic [7:0] ft, input logic [7:0] ar, input string nm);
    @(posedge clk); #1;
    start_addr = sa;
    end_addr   = ea;
    file_type  = ft;
    autorun    = ar;
    file_name  = pack_name(nm);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic run_save(input logic [15:0] sa, input logic [15:0] ea, input logic [7:0] ft,
                          input logic [7:0] ar, input string nm, input bit rnd, input bit poke);
    int total, n_data, d0, r0, e0, budget;
    bit seen = 1'b0;
    rnd_ready_en = rnd;
    total  = build_image(sa, ea, ft, ar, nm);
    n_data = int'(ea) - int'(sa) + 1;
    d0 = done_cnt; r0 = rd_cnt; e0 = err_cnt;
    budget = total * 8 + 50;
    pulse_start(sa, ea, ft, ar, nm);
    @(negedge clk);
    check("first_valid", 32'(tap_bus.tap_valid), 32'd1);
    check("first_addr", 32'(tap_bus.tap_addr), 32'd0);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      start_addr = 16'h0500;
      end_addr   = 16'h0400;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
    end
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("tap_length", 32'(tap_length), 32'(total));
    check("done_latency", 32'(cyc), 32'(acc_cyc + 1));
    check("rd_count", 32'(rd_cnt - r0), 32'(n_data));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("done_once", 32'(done_cnt - d0), 32'd1);
    check("no_error", 32'(err_cnt - e0), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
    check("length_held", 32'(tap_length), 32'(total));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, dummy, len;
    bit seen;
    logic [15:0] sa;
    string nm;

    for (int a = 0; a < 65536; a++) ram[a] = 8'($urandom);
    tap_bus.tap_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_valid", 32'(tap_bus.tap_valid), 32'd0);
    check("rst_addr", 32'(tap_bus.tap_addr), 32'd0);
    check("rst_dout", 32'(tap_bus.tap_dout), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_length", 32'(tap_length), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Directed cases.
    run_save(16'h0501, 16'h0503, FT_BASIC, AUTORUN_ON, "AB", 1'b0, 1'b0);
    run_save(16'h1000, 16'h1003, FT_MCODE, AUTORUN_OFF, "ORICSAVEFILE1234", 1'b0, 1'b0);
    run_save(16'h2000, 16'h2001, FT_MCODE, AUTORUN_ON, "ABCDEFGHIJKLMNOPQR", 1'b0, 1'b0);
    run_save(16'hFFFF, 16'hFFFF, FT_MCODE, AUTORUN_OFF, "Z", 1'b0, 1'b0);
    run_save(16'h3000, 16'h3004, FT_BASIC, AUTORUN_OFF, "", 1'b0, 1'b0);
    run_save(16'h0501, 16'h0503, FT_BASIC, AUTORUN_ON, "AB", 1'b1, 1'b1);
    run_save(16'hFFF0, 16'hFFFF, FT_MCODE, AUTORUN_ON, "TOP", 1'b1, 1'b0);

    // Rejected start.
    rnd_ready_en = 1'b0;
    e0 = err_cnt;
    pulse_start(16'h0500, 16'h0400, FT_BASIC, AUTORUN_OFF, "BAD");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("err_busy", 32'(busy), 32'd0);
      check("err_valid", 32'(tap_bus.tap_valid), 32'd0);
    end
    check("err_pulse", 32'(err_cnt - e0), 32'd1);

    // Randomized saves.
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 24);
      sa  = 16'($urandom_range(0, 65536 - len));
      nm  = "";
      for (int i = 0; i < int'($urandom_range(0, 18)); i++)
        nm = $sformatf("%s%c", nm, 8'(65 + $urandom_range(0, 25)));
      run_save(sa, 16'(int'(sa) + len - 1), ($urandom_range(0, 1) != 0) ? FT_MCODE : FT_BASIC,
               8'($urandom), nm, 1'b1, 1'b0);
    end

    // Reset during the data phase, then a complete save.
    rnd_ready_en = 1'b0;
    dummy = build_image(16'h2000, 16'h20FF, FT_MCODE, AUTORUN_ON, "RESET");
    d0 = done_cnt;
    seen = 1'b0;
    pulse_start(16'h2000, 16'h20FF, FT_MCODE, AUTORUN_ON, "RESET");
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_rd) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_data", 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(tap_bus.tap_valid), 32'd0);
    check("abort_addr", 32'(tap_bus.tap_addr), 32'd0);
    check("abort_dout", 32'(tap_bus.tap_dout), 32'd0);
    check("abort_mem_rd", 32'(mem_rd), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_length", 32'(tap_length), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_save(16'h2000, 16'h2010, FT_MCODE, AUTORUN_ON, "AFTER", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
